item_spawner: RTL and testbench
===============================

# item_spawner

Consumes 13-bit random words from the game's LFSR source and uses them to place a power-up item on a free cell of the play grid. On a spawn request it draws random words and decodes each into a cell coordinate and an item type. It probes the grid occupancy port and writes the item into the first free cell it finds. It gives up after a bounded number of draws. It sits between the random generator and the grid/tile memory controller, and the game FSM triggers it when a block is destroyed.

## Interface
- GRID_W, 15, grid width in cells (≤16)
- GRID_H, 13, grid height in cells (≤16)
- MAX_TRIES, 8, random words consumed per request before failing (≥1)
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- spawn_req  input  1  one-cycle request; honoured only in IDLE
- abort  input  1  synchronous cancel; forces IDLE, no write
- rnd  input  13  random word from generator
- rnd_valid  input  1  rnd is valid
- rnd_ready  output  1  spawner accepts rnd this cycle
- rd_en  output  1  occupancy probe strobe
- rd_x, rd_y  output  4 each  probe coordinate
- rd_occupied  input  1  occupancy result, valid the cycle after rd_en
- wr_en  output  1  item write strobe (one cycle)
- wr_x, wr_y  output  4 each  write coordinate
- wr_item  output  4  item code
- busy  output  1  high in any state except IDLE
- spawn_done  output  1  one-cycle pulse, item placed
- spawn_fail  output  1  one-cycle pulse, MAX_TRIES exhausted

## Operation
- Word decode: x = rnd[3:0], y = rnd[7:4], t = rnd[12:10]. rnd[9:8] are ignored.
- A word is rejected (it consumes a try, with no probe) if x ≥ GRID_W or y ≥ GRID_H.
- Type fold: if t ≥ 5 then t = t − 5.
- Item code map: 0→2, 1→4, 2→8, 3→6, 4→5.
- FSM states: IDLE, FETCH, PROBE, CHECK, PLACE, FAIL.
- IDLE: if spawn_req is high, clear tries and go to FETCH.
- FETCH: rnd_ready is high.
  - On rnd_valid, latch x, y and code, and increment tries.
  - If the word is valid, go to PROBE.
  - If the word is rejected and tries = MAX_TRIES, go to FAIL; otherwise stay in FETCH.
- PROBE: rd_en is high with the latched coordinate. Go to CHECK.
- CHECK: sample rd_occupied.
  - If it is 0, go to PLACE.
  - If it is 1 and tries = MAX_TRIES, go to FAIL; if it is 1 otherwise, go to FETCH.
- PLACE: wr_en and spawn_done are high with the latched x, y and code. Go to IDLE.
- FAIL: spawn_fail is high. Go to IDLE.
- The tries counter is $clog2(MAX_TRIES+1) bits wide. It saturates and never wraps.
- spawn_req is ignored while busy; it is not queued.
- abort has priority over every transition in every state.
  - The next state is IDLE and no wr_en, spawn_done or spawn_fail is issued.
  - If abort arrives in PLACE, the write is suppressed in that same cycle.
- wr_x, wr_y, wr_item, rd_x and rd_y hold their last latched value when their strobe is low.

## Timing
- Reset values: state IDLE; all strobes, pulses, busy and rnd_ready 0; coordinates, item and tries 0.
- rnd_ready is a registered-state output: high exactly in FETCH, independent of rnd_valid. The handshake completes on the cycle where both rnd_valid and rnd_ready are high.
- Best case with rnd_valid held high:
  - spawn_req at cycle 0
  - FETCH at cycle 1, word accepted
  - rd_en at cycle 2
  - rd_occupied sampled at cycle 3
  - wr_en and spawn_done at cycle 4
- Each rejected word adds 1 cycle. Each occupied probe adds 3 cycles (CHECK→FETCH→PROBE→CHECK).
- If rnd_valid is low, FETCH waits indefinitely. There is no timeout.
- Reset asserted mid-operation returns the block to IDLE immediately and asynchronously. No pulse is emitted.
- spawn_req in the cycle the block returns to IDLE from PLACE or FAIL is ignored. It is sampled again from the next cycle.

## Structure
- Shared package game_pkg holds:
  - the item code constants (ITEM_BOMB_UP=2, ITEM_FIRE_UP=4, ITEM_SPEED=8, ITEM_KICK=6, ITEM_LIFE=5)
  - the 4-bit item_t and coordinate typedefs
  - the spawner state enum
- One natural sub-module: item_decode. It is combinational: rnd in; x, y, valid and item code out.
- The FSM, tries counter and output registers live in item_spawner.

## Test plan
- Reset, then spawn_req with rnd=13'h0C35 held valid and rd_occupied=0. Required: rd_en at cycle 2 with (5,3); wr_en and spawn_done at cycle 4 with (5,3) and item 6.
- Rejection: rnd=13'h003F, then 13'h1C12. Required: first word consumed with no rd_en; write at (2,1) with item 8 (t=7 folds to 2).
- Occupied retry: rd_occupied=1 on the first probe, 0 on the second. Required: two rd_en strobes 3 cycles apart and exactly one wr_en.
- Exhaustion with MAX_TRIES=8 and every probe occupied. Required: 8 words accepted, spawn_fail pulse, no wr_en, busy low the next cycle.
- abort during PROBE, and separately abort during PLACE. Required: IDLE the next cycle, no wr_en, no done or fail pulse.
- Reset asserted mid-FETCH with rnd_valid=0. Required: all outputs 0 immediately; the next spawn_req starts a fresh request with tries cleared.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions used by the item spawner.
//   - item_t / coord_t : 4-bit item code and grid coordinate types
//   - ITEM_*           : power-up item codes written into the tile memory
//   - spawn_state_t    : item spawner FSM states
//   - item_code()      : maps a folded item type (0..4) to its item code
package game_pkg;

    typedef logic [3:0] item_t;
    typedef logic [3:0] coord_t;

    localparam item_t ITEM_BOMB_UP = 4'd2;
    localparam item_t ITEM_FIRE_UP = 4'd4;
    localparam item_t ITEM_SPEED   = 4'd8;
    localparam item_t ITEM_KICK    = 4'd6;
    localparam item_t ITEM_LIFE    = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PROBE = 3'd2,
        ST_CHECK = 3'd3,
        ST_PLACE = 3'd4,
        ST_FAIL  = 3'd5
    } spawn_state_t;

    function automatic item_t item_code(input logic [2:0] t);
        case (t)
            3'd0:    return ITEM_BOMB_UP;
            3'd1:    return ITEM_FIRE_UP;
            3'd2:    return ITEM_SPEED;
            3'd3:    return ITEM_KICK;
            3'd4:    return ITEM_LIFE;
            default: return ITEM_BOMB_UP;
        endcase
    endfunction

endpackage

// File: rtl/item_decode.sv
// Combinational decode of one 13-bit random word into a spawn candidate.
//   rnd_i   : random word (x = [3:0], y = [7:4], type = [12:10], [9:8] unused)
//   x_o/y_o : candidate cell coordinate
//   valid_o : coordinate lies inside the GRID_W x GRID_H play grid
//   item_o  : item code after folding the 3-bit type into 0..4
module item_decode
    import game_pkg::*;
#(
    parameter int GRID_W = 15,
    parameter int GRID_H = 13
) (
    input  logic [12:0] rnd_i,
    output coord_t      x_o,
    output coord_t      y_o,
    output logic        valid_o,
    output item_t       item_o
);

    logic [2:0] t_raw;
    logic [2:0] t_fold;
    logic       unused_bits;

    assign x_o         = rnd_i[3:0];
    assign y_o         = rnd_i[7:4];
    assign t_raw       = rnd_i[12:10];
    assign unused_bits = ^rnd_i[9:8];

    assign valid_o = (int'(x_o) < GRID_W) && (int'(y_o) < GRID_H);

    // Types 5..7 wrap back onto 0..2 so every word yields an item.
    assign t_fold = (t_raw >= 3'd5) ? (t_raw - 3'd5) : t_raw;
    assign item_o = item_code(t_fold);

endmodule

// File: rtl/item_spawner.sv
// Power-up item spawner. On a spawn request it draws random words, probes
// the grid occupancy for each in-range coordinate and writes the item into
// the first free cell; it gives up after MAX_TRIES words.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   spawn_req_i, abort_i   : request (IDLE only) / synchronous cancel
//   rnd_i, rnd_valid_i,
//   rnd_ready_o            : random word handshake (ready exactly in FETCH)
//   rd_en_o, rd_x_o, rd_y_o,
//   rd_occupied_i          : occupancy probe, result valid the cycle after
//   wr_en_o, wr_x_o, wr_y_o,
//   wr_item_o              : item write strobe and payload
//   busy_o                 : not IDLE
//   spawn_done_o/fail_o    : one-cycle completion pulses
module item_spawner
    import game_pkg::*;
#(
    parameter int GRID_W    = 15,
    parameter int GRID_H    = 13,
    parameter int MAX_TRIES = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        spawn_req_i,
    input  logic        abort_i,
    input  logic [12:0] rnd_i,
    input  logic        rnd_valid_i,
    output logic        rnd_ready_o,
    output logic        rd_en_o,
    output coord_t      rd_x_o,
    output coord_t      rd_y_o,
    input  logic        rd_occupied_i,
    output logic        wr_en_o,
    output coord_t      wr_x_o,
    output coord_t      wr_y_o,
    output item_t       wr_item_o,
    output logic        busy_o,
    output logic        spawn_done_o,
    output logic        spawn_fail_o
);

    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

    spawn_state_t  state_q, state_d;
    logic [TW-1:0] tries_q, tries_d;
    coord_t        x_q, x_d;
    coord_t        y_q, y_d;
    item_t         item_q, item_d;

    coord_t        dec_x;
    coord_t        dec_y;
    logic          dec_valid;
    item_t         dec_item;

    item_decode #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) u_decode (
        .rnd_i  (rnd_i),
        .x_o    (dec_x),
        .y_o    (dec_y),
        .valid_o(dec_valid),
        .item_o (dec_item)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            tries_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            item_q  <= '0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            x_q     <= x_d;
            y_q     <= y_d;
            item_q  <= item_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        x_d          = x_q;
        y_d          = y_q;
        item_d       = item_q;
        rnd_ready_o  = 1'b0;
        rd_en_o      = 1'b0;
        wr_en_o      = 1'b0;
        spawn_done_o = 1'b0;
        spawn_fail_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (spawn_req_i) begin
                    tries_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rnd_ready_o = 1'b1;
                if (rnd_valid_i) begin
                    x_d    = dec_x;
                    y_d    = dec_y;
                    item_d = dec_item;
                    if (tries_q != TRIES_MAX) begin
                        tries_d = tries_q + 1'b1;
                    end
                    // Decision uses the count including this word.
                    if (dec_valid) begin
                        state_d = ST_PROBE;
                    end else if (tries_d == TRIES_MAX) begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_PROBE: begin
                rd_en_o = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!rd_occupied_i) begin
                    state_d = ST_PLACE;
                end else if (tries_q == TRIES_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_PLACE: begin
                wr_en_o      = 1'b1;
                spawn_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            ST_FAIL: begin
                spawn_fail_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel wins over every transition and masks same-cycle write/pulses.
        if (abort_i) begin
            state_d      = ST_IDLE;
            wr_en_o      = 1'b0;
            spawn_done_o = 1'b0;
            spawn_fail_o = 1'b0;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign rd_x_o    = x_q;
    assign rd_y_o    = y_q;
    assign wr_x_o    = x_q;
    assign wr_y_o    = y_q;
    assign wr_item_o = item_q;

endmodule

// File: tb/tb_item_spawner.sv
// Self-checking bench for item_spawner: directed scenarios followed by
// randomized requests compared against a behavioural outcome model.
module tb_item_spawner;

    localparam int GW = 15;
    localparam int GH = 13;
    localparam int MT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_req, abort_s, rnd_valid, rd_occupied;
    logic [12:0] rnd;
    logic        rnd_ready, rd_en, wr_en, busy, spawn_done, spawn_fail;
    logic [3:0]  rd_x, rd_y, wr_x, wr_y, wr_item;

    int n_vec = 0;
    int n_err = 0;

    int items[5] = '{2, 4, 8, 6, 5};

    // stimulus for one request
    int words[$];
    bit occ[$];

    // model prediction
    int exp_px[$], exp_py[$], exp_pc[$];
    bit exp_fail;
    int exp_wx, exp_wy, exp_item, exp_end, exp_nw;

    // observed outcome of the last request
    int got_px[$], got_py[$], got_pc[$];
    int got_end, got_nw, got_nwr, got_wx, got_wy, got_item;
    logic got_done, got_fail;

    always #5 clk = ~clk;

    item_spawner #(
        .GRID_W(GW),
        .GRID_H(GH),
        .MAX_TRIES(MT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .spawn_req_i  (spawn_req),
        .abort_i      (abort_s),
        .rnd_i        (rnd),
        .rnd_valid_i  (rnd_valid),
        .rnd_ready_o  (rnd_ready),
        .rd_en_o      (rd_en),
        .rd_x_o       (rd_x),
        .rd_y_o       (rd_y),
        .rd_occupied_i(rd_occupied),
        .wr_en_o      (wr_en),
        .wr_x_o       (wr_x),
        .wr_y_o       (wr_y),
        .wr_item_o    (wr_item),
        .busy_o       (busy),
        .spawn_done_o (spawn_done),
        .spawn_fail_o (spawn_fail)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".rnd_ready"}, rnd_ready, 0);
        chk({tag, ".rd_en"}, rd_en, 0);
        chk({tag, ".wr_en"}, wr_en, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, spawn_done, 0);
        chk({tag, ".fail"}, spawn_fail, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_quiet(tag);
        chk({tag, ".rd_x"}, rd_x, 0);
        chk({tag, ".rd_y"}, rd_y, 0);
        chk({tag, ".wr_x"}, wr_x, 0);
        chk({tag, ".wr_y"}, wr_y, 0);
        chk({tag, ".wr_item"}, wr_item, 0);
    endtask

    function automatic int mkword(input int x, input int y, input int t);
        return (t << 10) | ($urandom_range(0, 3) << 8) | (y << 4) | x;
    endfunction

    task automatic pad_words();
        while (words.size() < MT) words.push_back(mkword($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7)));
        while (occ.size() < MT) occ.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Outcome of a request from the rules: each out-of-grid word costs one
    // FETCH cycle; each in-grid word costs FETCH+PROBE+CHECK; the request
    // ends at the first free probe or after MT words.
    task automatic model();
        int cyc = 1;
        int oi = 0;
        exp_px.delete(); exp_py.delete(); exp_pc.delete();
        exp_fail = 1'b1; exp_nw = 0; exp_wx = 0; exp_wy = 0; exp_item = 0;
        for (int k = 0; k < MT; k++) begin
            int w = words[k];
            int x = w % 16;
            int y = (w / 16) % 16;
            int t = (w / 1024) % 8;
            exp_nw++;
            if (x >= GW || y >= GH) begin
                cyc += 1;
            end else begin
                exp_px.push_back(x); exp_py.push_back(y); exp_pc.push_back(cyc + 1);
                cyc += 3;
                if (!occ[oi]) begin
                    exp_fail = 1'b0; exp_wx = x; exp_wy = y; exp_item = items[t % 5];
                    break;
                end
                oi++;
            end
        end
        exp_end = cyc;
    endtask

    task automatic run_req(input string tag);
        int wi = 0;
        int pi = 0;
        logic prev_rdy = 1'b0;
        logic prev_rden = 1'b0;
        model();
        got_px.delete(); got_py.delete(); got_pc.delete();
        got_end = -1; got_nwr = 0; got_wx = 0; got_wy = 0; got_item = 0;
        got_done = 1'b0; got_fail = 1'b0;
        step();
        spawn_req = 1'b1; rnd_valid = 1'b1; abort_s = 1'b0;
        rnd = 13'(words[0]); rd_occupied = 1'($urandom);
        prev_rdy = rnd_ready;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (prev_rdy && rnd_valid) wi++;
            if (rd_en) begin got_px.push_back(rd_x); got_py.push_back(rd_y); got_pc.push_back(c); end
            if (wr_en) begin got_nwr++; got_wx = wr_x; got_wy = wr_y; got_item = wr_item; end
            spawn_req = 1'($urandom);
            if (spawn_done || spawn_fail) begin
                got_done = spawn_done; got_fail = spawn_fail; got_end = c;
                break;
            end
            rnd = (wi < MT) ? 13'(words[wi]) : 13'($urandom);
            if (prev_rden) begin rd_occupied = occ[pi]; pi++; end
            else rd_occupied = 1'($urandom);
            prev_rden = rd_en;
            prev_rdy  = rnd_ready;
        end
        got_nw = wi;
        step();
        spawn_req = 1'b0;
        chk({tag, ".end_cycle"}, got_end, exp_end);
        chk({tag, ".fail"}, got_fail, exp_fail);
        chk({tag, ".done"}, got_done, !exp_fail);
        chk({tag, ".words"}, got_nw, exp_nw);
        chk({tag, ".n_wr"}, got_nwr, exp_fail ? 0 : 1);
        chk({tag, ".n_probe"}, got_px.size(), exp_px.size());
        for (int i = 0; i < got_px.size() && i < exp_px.size(); i++) begin
            chk({tag, ".probe_x"}, got_px[i], exp_px[i]);
            chk({tag, ".probe_y"}, got_py[i], exp_py[i]);
            chk({tag, ".probe_cyc"}, got_pc[i], exp_pc[i]);
        end
        if (!exp_fail) begin
            chk({tag, ".wr_x"}, got_wx, exp_wx);
            chk({tag, ".wr_y"}, got_wy, exp_wy);
            chk({tag, ".wr_item"}, got_item, exp_item);
            chk({tag, ".wr_x_hold"}, wr_x, exp_wx);
        end
        chk({tag, ".busy_after"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; spawn_req = 1'b0; abort_s = 1'b0; rnd_valid = 1'b0;
        rnd = '0; rd_occupied = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // best case
        words.delete(); occ.delete();
        words.push_back('h0C35); occ.push_back(1'b0); pad_words();
        run_req("best");
        chk("best.cycle", got_end, 4);
        chk("best.rd_cyc", got_pc.size() > 0 ? got_pc[0] : -1, 2);
        chk("best.rd_x", got_px.size() > 0 ? got_px[0] : -1, 5);
        chk("best.rd_y", got_py.size() > 0 ? got_py[0] : -1, 3);
        chk("best.wx", got_wx, 5);
        chk("best.wy", got_wy, 3);
        chk("best.item", got_item, 6);

        // rejected word, then fold of type 7
        words.delete(); occ.delete();
        words.push_back('h003F); words.push_back('h1C12); occ.push_back(1'b0); pad_words();
        run_req("reject");
        chk("reject.n_probe", got_px.size(), 1);
        chk("reject.wx", got_wx, 2);
        chk("reject.wy", got_wy, 1);
        chk("reject.item", got_item, 8);
        chk("reject.cycle", got_end, 5);

        // occupied then free
        words.delete(); occ.delete();
        words.push_back('h0C35); words.push_back('h1C12);
        occ.push_back(1'b1); occ.push_back(1'b0); pad_words();
        run_req("retry");
        chk("retry.n_probe", got_px.size(), 2);
        chk("retry.gap", got_pc.size() == 2 ? got_pc[1] - got_pc[0] : -1, 3);
        chk("retry.n_wr", got_nwr, 1);

        // exhaustion: every probe occupied
        words.delete(); occ.delete();
        for (int i = 0; i < MT; i++) begin
            words.push_back(mkword($urandom_range(0, GW - 1), $urandom_range(0, GH - 1), $urandom_range(0, 7)));
            occ.push_back(1'b1);
        end
        run_req("exhaust");
        chk("exhaust.words", got_nw, 8);
        chk("exhaust.fail", got_fail, 1);
        chk("exhaust.n_wr", got_nwr, 0);
        chk("exhaust.cycle", got_end, 25);

        // abort during PROBE
        spawn_req = 1'b1; rnd = 13'h0C35; rnd_valid = 1'b1; rd_occupied = 1'b0;
        step(); spawn_req = 1'b0;
        step();
        chk("abort_probe.rd_en", rd_en, 1);
        abort_s = 1'b1;
        step(); abort_s = 1'b0;
        chk_quiet("abort_probe.next");
        repeat (4) begin
            step();
            chk_quiet("abort_probe.later");
        end

        // abort during PLACE: write masked in the same cycle
        spawn_req = 1'b1;
        step(); spawn_req = 1'b0;
        step(); step(); step();
        chk("abort_place.wr_en_pre", wr_en, 1);
        abort_s = 1'b1;
        #1;
        chk("abort_place.wr_en", wr_en, 0);
        chk("abort_place.done", spawn_done, 0);
        step(); abort_s = 1'b0;
        chk_quiet("abort_place.next");
        step();
        chk_quiet("abort_place.later");

        // reset while waiting in FETCH after consuming some words
        spawn_req = 1'b1; rnd = 13'h00FF; rnd_valid = 1'b1;
        step(); spawn_req = 1'b0;
        step(); step();
        rnd_valid = 1'b0;
        step(); step();
        chk("midreset.rnd_ready", rnd_ready, 1);
        chk("midreset.busy", busy, 1);
        chk("midreset.rd_x", rd_x, 15);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset.async");
        @(negedge clk);
        rst_n = 1'b1;
        words.delete(); occ.delete();
        for (int i = 0; i < MT; i++) begin
            words.push_back(mkword($urandom_range(0, GW - 1), $urandom_range(0, GH - 1), $urandom_range(0, 7)));
            occ.push_back(1'b1);
        end
        run_req("after_reset");
        chk("after_reset.words", got_nw, 8);

        // randomized requests
        for (int r = 0; r < 40; r++) begin
            words.delete(); occ.delete();
            pad_words();
            run_req("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
